// File: rtl/otter_io_pkg.sv
// Shared OTTER I/O map constants and seven-segment scan driver types.
// Address constants are the defaults; blocks take them as overridable parameters.
package otter_io_pkg;

  localparam logic [31:0] SWITCHES_ADDR  = 32'h1100_0000;
  localparam logic [31:0] LEDS_ADDR      = 32'h1100_C000;
  localparam logic [31:0] SSEG_SEG_ADDR  = 32'h1100_C004;
  localparam logic [31:0] SSEG_AN_ADDR   = 32'h1100_C008;
  localparam logic [31:0] TIMER_ADDR     = 32'h1100_C00C;
  localparam logic [31:0] SSEG_DATA_ADDR = 32'h1100_C010;
  localparam logic [31:0] SSEG_CTRL_ADDR = 32'h1100_C014;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_LZB_BIT = 1;
  localparam int CTRL_DP_LSB  = 2;

  localparam logic [5:0] CTRL_RESET = 6'b000001;
  localparam logic [7:0] SEGS_OFF   = 8'hFF;
  localparam logic [3:0] AN_OFF     = 4'hF;

  typedef enum logic {
    SCAN = 1'b0,
    GAP  = 1'b1
  } sseg_state_e;

endpackage

// File: rtl/sseg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern, bit order g..a.
module sseg_hex_decode (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h7F;
    case (nibble_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/sseg_scan_driver.sv
// Memory-mapped four-digit seven-segment scanner with dp, leading-zero blanking
// and an all-off gap between digits.
//   state | meaning
//   SCAN  | digit idx lit for REFRESH_CNT cycles
//   GAP   | all anodes off for BLANK_CYC cycles, then advance idx
module sseg_scan_driver
  import otter_io_pkg::*;
#(
  parameter logic [31:0] DATA_ADDR   = SSEG_DATA_ADDR,
  parameter logic [31:0] CTRL_ADDR   = SSEG_CTRL_ADDR,
  parameter int          REFRESH_CNT = 50000,
  parameter int          BLANK_CYC   = 500
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] RDATA,
  output logic [7:0]  SEGS,
  output logic [3:0]  AN
);

  localparam int CNT_MAX = (REFRESH_CNT > BLANK_CYC) ? REFRESH_CNT : BLANK_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] REF_TC = CNT_W'(REFRESH_CNT - 1);
  localparam logic [CNT_W-1:0] GAP_TC = CNT_W'(BLANK_CYC - 1);

  logic [15:0]      data_q;
  logic [5:0]       ctrl_q;
  sseg_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       segs_q, segs_d;
  logic [3:0]       an_q, an_d;

  logic [3:0] nibble;
  logic [6:0] seg7;
  logic       lz_blank;
  logic       unused_hi;

  assign unused_hi = ^IOBUS_OUT[31:16];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      data_q <= '0;
      ctrl_q <= CTRL_RESET;
    end else if (IOBUS_WR) begin
      if (IOBUS_ADDR == DATA_ADDR) data_q <= IOBUS_OUT[15:0];
      if (IOBUS_ADDR == CTRL_ADDR) ctrl_q <= IOBUS_OUT[5:0];
    end
  end

  always_comb begin
    RDATA = '0;
    if (IOBUS_ADDR == DATA_ADDR)      RDATA = {16'b0, data_q};
    else if (IOBUS_ADDR == CTRL_ADDR) RDATA = {26'b0, ctrl_q};
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= SCAN;
      cnt_q   <= '0;
      idx_q   <= '0;
      segs_q  <= SEGS_OFF;
      an_q    <= AN_OFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      segs_q  <= segs_d;
      an_q    <= an_d;
    end
  end

  // With no gap configured the digit advances straight from SCAN's terminal count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    case (state_q)
      SCAN: begin
        if (cnt_q == REF_TC) begin
          cnt_d = '0;
          if (BLANK_CYC == 0) idx_d = idx_q + 2'd1;
          else                state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q == GAP_TC) begin
          cnt_d   = '0;
          state_d = SCAN;
          idx_d   = idx_q + 2'd1;
        end
      end
      default: begin
        state_d = SCAN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    nibble   = data_q[3:0];
    lz_blank = 1'b0;
    case (idx_q)
      2'd0: nibble = data_q[3:0];
      2'd1: begin nibble = data_q[7:4];   lz_blank = (data_q[15:4] == '0);  end
      2'd2: begin nibble = data_q[11:8];  lz_blank = (data_q[15:8] == '0);  end
      2'd3: begin nibble = data_q[15:12]; lz_blank = (data_q[15:12] == '0); end
      default: nibble = data_q[3:0];
    endcase
  end

  sseg_hex_decode u_hex (
    .nibble_i (nibble),
    .seg_o    (seg7)
  );

  always_comb begin
    segs_d = SEGS_OFF;
    an_d   = AN_OFF;
    if (state_q == SCAN && ctrl_q[CTRL_EN_BIT] &&
        !(ctrl_q[CTRL_LZB_BIT] && lz_blank)) begin
      segs_d = {~ctrl_q[CTRL_DP_LSB + 32'(idx_q)], seg7};
      an_d   = ~(4'b0001 << idx_q);
    end
  end

  assign SEGS = segs_q;
  assign AN   = an_q;

endmodule

// File: doc/sseg_scan_driver.md
# sseg_scan_driver

Memory-mapped, multiplexed four-digit seven-segment display controller for the Basys3 board. It sits on the OTTER I/O bus beside the board-level wrapper, consumes the CPU's store traffic (address, data, write strobe), and replaces raw software-driven cathode/anode bit-banging with hardware scanning. Features: hex decode, per-digit decimal points, leading-zero blanking, and an anti-ghosting gap between digits. Its `SEGS`/`AN` outputs drive the board pins; its `RDATA` is ORed into the wrapper's `IOBUS_in` mux.

## Interface
- `DATA_ADDR`, default 32'h1100C010: address of the 16-bit hex value register.
- `CTRL_ADDR`, default 32'h1100C014: address of the control register.
- `REFRESH_CNT`, default 50000: clock cycles each digit is lit (1 ms at 50 MHz); must be ≥ 2.
- `BLANK_CYC`, default 500: all-anodes-off cycles between digits; 0 removes the gap.
- `CLK`  in  1  system clock (50 MHz domain). One clock; no other domains.
- `RESET`  in  1  asynchronous, active-high reset.
- `IOBUS_ADDR`  in  32  bus address.
- `IOBUS_OUT`  in  32  CPU store data.
- `IOBUS_WR`  in  1  store strobe; qualifies `IOBUS_ADDR`/`IOBUS_OUT` for one cycle.
- `RDATA`  out  32  combinational readback: data reg at `DATA_ADDR`, ctrl reg at `CTRL_ADDR`, else 0.
- `SEGS`  out  8  active-low cathodes: `SEGS[0]`=a … `SEGS[6]`=g, `SEGS[7]`=dp.
- `AN`  out  4  active-low anodes: `AN[0]` is the rightmost digit.

## Operation
- Data reg is 16 bits, written from `IOBUS_OUT[15:0]`. Digit k shows nibble `data[4k+3:4k]`.
- Ctrl reg is 6 bits, written from `IOBUS_OUT[5:0]`:
  - bit0: EN, display enable.
  - bit1: LZB, leading-zero blanking.
  - bits[5:2]: DP mask. Bit 2+k lights the dp of digit k.
- Register reset values: data=0, ctrl=6'b000001 (enabled, LZB off, no dp).
- A store whose address matches neither register is ignored. Upper data bits are ignored.
- Hex decode, active-low, bits g..a:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
  - `SEGS[7]` = ~dp.
- Leading-zero blanking, applied only when LZB=1:
  - digit 3 blank if nibble3==0;
  - digit 2 blank if nibbles 3..2 == 0;
  - digit 1 blank if nibbles 3..1 == 0;
  - digit 0 never blanks.
  - A blanked digit drives `AN`=4'hF and `SEGS`=8'hFF for its whole slot; the scan timing is unchanged.
- FSM states:
  - SCAN: the digit at index `idx` is lit. A cycle counter runs 0..`REFRESH_CNT`-1. At the terminal count, go to GAP with the counter cleared; if `BLANK_CYC`=0, go directly to SCAN with `idx`+1.
  - GAP: `AN`=4'hF, `SEGS`=8'hFF. Counter runs 0..`BLANK_CYC`-1, then go to SCAN with `idx`+1.
- `idx` is a 2-bit index that wraps 3→0.
- EN=0:
  - `AN`=4'hF and `SEGS`=8'hFF.
  - The FSM and counter keep running, so re-enabling resumes scanning with no resync.
- Simultaneous events: a register write and a digit advance in the same cycle both take effect. The newly lit digit uses the new register value one cycle later, per the latency rule in Timing.

## Timing
- `SEGS` and `AN` are registered.
- Reset: `SEGS`=8'hFF, `AN`=4'hF, state=SCAN, `idx`=0, counter=0.
  - First lit output appears on the first edge after reset deasserts: `AN`=4'hE, `SEGS`=C0.
- Reset asserted mid-scan forces the reset values immediately (asynchronous), including register contents.
- Write latency: a store is sampled at edge N; the register updates at edge N. `SEGS`/`AN` reflect the new value from edge N+1 if the current digit is lit.
- Scan period: 4×(`REFRESH_CNT`+`BLANK_CYC`) cycles. Each digit is lit for exactly `REFRESH_CNT` consecutive cycles.
- `RDATA` has zero latency: combinational from `IOBUS_ADDR` and the current register values.

## Structure
- Shared package `otter_io_pkg`:
  - I/O address constants (`DATA_ADDR`/`CTRL_ADDR` defaults alongside the existing LED/SEG/ANODE/timer addresses);
  - ctrl-bit position constants;
  - state enum {SCAN, GAP}.
- Sub-module `sseg_hex_decode`: purely combinational, 4-bit nibble → 7-bit active-low segments. Reused by any future display block.

## Test plan
All tests use `REFRESH_CNT`=8, `BLANK_CYC`=2, period 40 cycles.
1. **Reset:** hold `RESET` for 3 cycles → `SEGS`=FF, `AN`=F. After release, `AN` goes E→F (gap)→D→F→B→F→7 every 10 cycles, with `SEGS`=C0 whenever lit.
2. **Hex decode:** write 16'hA1F9 to `DATA_ADDR` → digits 0..3 show `SEGS` 90, 8E, F9, 88. `RDATA` reads 0x0000A1F9 at `DATA_ADDR`.
3. **Leading-zero blanking and dp:** write data 16'h0005 and ctrl 6'b100011 (dp on digit 3, LZB on) → digit 0 shows 92 (`AN`=E). Digits 1–3 are blank (`AN`=F, `SEGS`=FF) despite the dp bit. Then write data 16'h8005 → digit 3 shows 00 (8 with dp), and digits 2 and 1 show C0.
4. **Disable mid-scan:** write ctrl=0 mid-digit → next edge `AN`=F, `SEGS`=FF. Write ctrl=1 → scanning resumes at the correct phase (same `idx` as an undisabled reference model).
5. **Write during the lit slot, and stray address:** write digit 0's nibble while digit 0 is lit → `SEGS` changes exactly one edge later. A store to 0x1100C018 leaves both registers and `RDATA` unchanged.
6. **Async reset mid-GAP:** pulse `RESET` between edges → outputs go FF/F without waiting for a clock edge, and registers return to data=0, ctrl=1.
